// File: rtl/rom_load_seq.sv
// ROM download sequencer: steers host download bytes into the ROM stores and
// holds the game core in reset until a download (or external reset) settles.
module rom_load_seq #(
    parameter logic [16:0] ROM_SIZE    = 17'h10000,
    parameter logic [15:0] HOLD_CYCLES = 16'd1024,
    parameter logic [15:0] SND_BASE    = 16'h4000,
    parameter logic [15:0] GFX_BASE    = 16'h5800
) (
    input  logic        clk_sys,
    input  logic        RESET_N,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic        ext_reset,
    output logic [15:0] dn_addr,
    output logic [7:0]  dn_data,
    output logic        dn_wr,
    output logic [2:0]  dn_sel,
    output logic        core_reset,
    output logic        loaded,
    output logic [16:0] byte_cnt,
    output logic [7:0]  checksum,
    output logic        overflow
);

    localparam int unsigned ADDR_W = 25;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2,
        RUN  = 2'd3
    } state_t;

    state_t      state;
    logic [15:0] hold_cnt;

    logic       in_range_c;
    logic       wr_ok_c;
    logic       wr_bad_c;
    logic       enter_load_c;
    logic [2:0] sel_c;

    assign in_range_c   = ioctl_addr < ADDR_W'(ROM_SIZE);
    assign wr_ok_c      = (state == LOAD) && ioctl_wr && in_range_c;
    assign wr_bad_c     = (state == LOAD) && ioctl_wr && !in_range_c;
    assign enter_load_c = ioctl_download && (state != LOAD);

    // Region decode on the full host address so out-of-window high bits never alias.
    always_comb begin
        sel_c = 3'b100;
        if (ioctl_addr < ADDR_W'(SND_BASE)) begin
            sel_c = 3'b001;
        end else if (ioctl_addr < ADDR_W'(GFX_BASE)) begin
            sel_c = 3'b010;
        end
    end

    // Only RUN lets the core out of reset, and then only if nobody else holds it.
    assign core_reset = (state == RUN) ? ext_reset : 1'b1;

    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= IDLE;
            hold_cnt <= 16'd0;
            dn_addr  <= 16'd0;
            dn_data  <= 8'd0;
            dn_wr    <= 1'b0;
            dn_sel   <= 3'b000;
            loaded   <= 1'b0;
            byte_cnt <= 17'd0;
            checksum <= 8'd0;
            overflow <= 1'b0;
        end else begin
            dn_wr  <= 1'b0;
            dn_sel <= 3'b000;

            if (wr_ok_c) begin
                dn_wr    <= 1'b1;
                dn_addr  <= ioctl_addr[15:0];
                dn_data  <= ioctl_dout;
                dn_sel   <= sel_c;
                checksum <= checksum + ioctl_dout;
                if (byte_cnt != 17'h1FFFF) begin
                    byte_cnt <= byte_cnt + 17'd1;
                end
            end

            if (wr_bad_c) begin
                overflow <= 1'b1;
            end

            if (enter_load_c) begin
                byte_cnt <= 17'd0;
                checksum <= 8'd0;
                overflow <= 1'b0;
                loaded   <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (ioctl_download) begin
                        state <= LOAD;
                    end else begin
                        state    <= HOLD;
                        hold_cnt <= HOLD_CYCLES - 16'd1;
                    end
                end
                LOAD: begin
                    // A byte rejected on the closing cycle still disqualifies the image.
                    if (!ioctl_download) begin
                        state    <= HOLD;
                        hold_cnt <= HOLD_CYCLES - 16'd1;
                        loaded   <= ~(overflow | wr_bad_c);
                    end
                end
                HOLD: begin
                    if (ioctl_download) begin
                        state <= LOAD;
                    end else if (hold_cnt == 16'd0) begin
                        state <= RUN;
                    end else begin
                        hold_cnt <= hold_cnt - 16'd1;
                    end
                end
                RUN: begin
                    if (ioctl_download) begin
                        state <= LOAD;
                    end else if (ext_reset) begin
                        state    <= HOLD;
                        hold_cnt <= HOLD_CYCLES - 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rom_load_seq.sv
// Directed bench for rom_load_seq: vector table for download traffic plus
// hand sequences for hold timing, external reset and mid-download reset.
module tb_rom_load_seq;

    localparam logic [16:0] ROM_SIZE_TB = 17'h6000;
    localparam int          HOLD_TB     = 8;

    logic        clk_sys = 1'b0;
    logic        RESET_N;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ext_reset;
    logic [15:0] dn_addr;
    logic [7:0]  dn_data;
    logic        dn_wr;
    logic [2:0]  dn_sel;
    logic        core_reset;
    logic        loaded;
    logic [16:0] byte_cnt;
    logic [7:0]  checksum;
    logic        overflow;

    int checks   = 0;
    int failures = 0;

    rom_load_seq #(
        .ROM_SIZE    (ROM_SIZE_TB),
        .HOLD_CYCLES (16'(HOLD_TB)),
        .SND_BASE    (16'h4000),
        .GFX_BASE    (16'h5800)
    ) dut (
        .clk_sys        (clk_sys),
        .RESET_N        (RESET_N),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ext_reset      (ext_reset),
        .dn_addr        (dn_addr),
        .dn_data        (dn_data),
        .dn_wr          (dn_wr),
        .dn_sel         (dn_sel),
        .core_reset     (core_reset),
        .loaded         (loaded),
        .byte_cnt       (byte_cnt),
        .checksum       (checksum),
        .overflow       (overflow)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic        dl;
        logic        wr;
        logic [24:0] addr;
        logic [7:0]  data;
        logic        e_wr;
        logic [2:0]  e_sel;
        logic [16:0] e_cnt;
        logic [7:0]  e_sum;
        logic        e_ovf;
        logic        e_loaded;
    } row_t;

    row_t rows [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, " core_reset"}, 32'(core_reset), 32'd1);
        chk({tag, " dn_wr"},      32'(dn_wr),      32'd0);
        chk({tag, " dn_sel"},     32'(dn_sel),     32'd0);
        chk({tag, " dn_addr"},    32'(dn_addr),    32'd0);
        chk({tag, " dn_data"},    32'(dn_data),    32'd0);
        chk({tag, " byte_cnt"},   32'(byte_cnt),   32'd0);
        chk({tag, " checksum"},   32'(checksum),   32'd0);
        chk({tag, " overflow"},   32'(overflow),   32'd0);
        chk({tag, " loaded"},     32'(loaded),     32'd0);
    endtask

    // Drive one row, clock it, then compare the registered response.
    task automatic apply_row(input int i);
        row_t r;
        string tag;
        r = rows[i];
        tag = $sformatf("row%0d", i);
        ioctl_download = r.dl;
        ioctl_wr       = r.wr;
        ioctl_addr     = r.addr;
        ioctl_dout     = r.data;
        @(posedge clk_sys);
        #1;
        ioctl_wr = 1'b0;
        chk({tag, " dn_wr"},    32'(dn_wr),    32'(r.e_wr));
        chk({tag, " dn_sel"},   32'(dn_sel),   32'(r.e_sel));
        chk({tag, " byte_cnt"}, 32'(byte_cnt), 32'(r.e_cnt));
        chk({tag, " checksum"}, 32'(checksum), 32'(r.e_sum));
        chk({tag, " overflow"}, 32'(overflow), 32'(r.e_ovf));
        chk({tag, " loaded"},   32'(loaded),   32'(r.e_loaded));
        if (r.e_wr) begin
            chk({tag, " dn_addr"}, 32'(dn_addr), 32'(r.addr[15:0]));
            chk({tag, " dn_data"}, 32'(dn_data), 32'(r.data));
        end
    endtask

    initial begin
        int n;

        //           dl    wr    addr       data   e_wr  e_sel   e_cnt  e_sum  ovf   loaded
        rows[0]  = '{1'b1, 1'b0, 25'h00000, 8'h00, 1'b0, 3'b000, 17'd0, 8'h00, 1'b0, 1'b0};
        rows[1]  = '{1'b1, 1'b1, 25'h00000, 8'h01, 1'b1, 3'b001, 17'd1, 8'h01, 1'b0, 1'b0};
        rows[2]  = '{1'b1, 1'b0, 25'h00000, 8'h00, 1'b0, 3'b000, 17'd1, 8'h01, 1'b0, 1'b0};
        rows[3]  = '{1'b1, 1'b1, 25'h04000, 8'h02, 1'b1, 3'b010, 17'd2, 8'h03, 1'b0, 1'b0};
        rows[4]  = '{1'b0, 1'b1, 25'h05800, 8'h03, 1'b1, 3'b100, 17'd3, 8'h06, 1'b0, 1'b1};
        rows[5]  = '{1'b1, 1'b0, 25'h00000, 8'h00, 1'b0, 3'b000, 17'd0, 8'h00, 1'b0, 1'b0};
        rows[6]  = '{1'b1, 1'b1, 25'h03FFF, 8'h10, 1'b1, 3'b001, 17'd1, 8'h10, 1'b0, 1'b0};
        rows[7]  = '{1'b1, 1'b1, 25'h057FF, 8'hF0, 1'b1, 3'b010, 17'd2, 8'h00, 1'b0, 1'b0};
        rows[8]  = '{1'b1, 1'b1, 25'h06000, 8'hAA, 1'b0, 3'b000, 17'd2, 8'h00, 1'b1, 1'b0};
        rows[9]  = '{1'b1, 1'b1, 25'h05FFF, 8'h80, 1'b1, 3'b100, 17'd3, 8'h80, 1'b1, 1'b0};
        rows[10] = '{1'b1, 1'b1, 25'h10000, 8'h55, 1'b0, 3'b000, 17'd3, 8'h80, 1'b1, 1'b0};
        rows[11] = '{1'b0, 1'b0, 25'h00000, 8'h00, 1'b0, 3'b000, 17'd3, 8'h80, 1'b1, 1'b0};

        RESET_N        = 1'b0;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = 25'h0;
        ioctl_dout     = 8'h0;
        ext_reset      = 1'b0;
        repeat (3) @(posedge clk_sys);
        #1;
        chk_reset_values("por");

        // Release with no download: core reset drops HOLD+1 cycles later.
        RESET_N = 1'b1;
        n = 0;
        do begin
            @(posedge clk_sys);
            #1;
            n++;
        end while (core_reset && n < 50);
        chk("release_to_run_cycles", 32'(n), 32'(HOLD_TB + 1));
        chk("run core_reset", 32'(core_reset), 32'd0);

        // One-cycle ext_reset in RUN: that cycle plus a full hold.
        ext_reset = 1'b1;
        #1;
        chk("ext_reset comb", 32'(core_reset), 32'd1);
        n = 1;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk_sys);
            #1;
            ext_reset = 1'b0;
            #1;
            if (!core_reset) break;
            n++;
        end
        chk("ext_reset_high_cycles", 32'(n), 32'(HOLD_TB + 1));

        // Download whose last strobe coincides with download falling.
        for (int i = 0; i <= 4; i++) apply_row(i);
        chk("trail core_reset", 32'(core_reset), 32'd1);
        n = 1;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk_sys);
            #1;
            if (k == 0) chk("no_second_trailing_wr", 32'(dn_wr), 32'd0);
            if (!core_reset) break;
            n++;
        end
        chk("hold_cycles_after_download", 32'(n), 32'(HOLD_TB));

        // Second download from RUN with sub-region boundaries and rejected bytes.
        for (int i = 5; i <= 11; i++) apply_row(i);

        // Download rising during HOLD restarts the load with cleared counters.
        repeat (2) @(posedge clk_sys);
        #1;
        chk("hold core_reset", 32'(core_reset), 32'd1);
        ioctl_download = 1'b1;
        @(posedge clk_sys);
        #1;
        chk("reload byte_cnt", 32'(byte_cnt), 32'd0);
        chk("reload checksum", 32'(checksum), 32'd0);
        chk("reload overflow", 32'(overflow), 32'd0);
        ioctl_wr   = 1'b1;
        ioctl_addr = 25'h00010;
        ioctl_dout = 8'h77;
        @(posedge clk_sys);
        #1;
        chk("reload dn_wr", 32'(dn_wr), 32'd1);
        chk("reload dn_sel", 32'(dn_sel), 32'b001);
        chk("reload byte_cnt after wr", 32'(byte_cnt), 32'd1);

        // Reset asserted mid-cycle with a write strobe live and another queued.
        #2;
        RESET_N = 1'b0;
        #1;
        chk_reset_values("abort");
        @(posedge clk_sys);
        #1;
        chk("abort held dn_wr", 32'(dn_wr), 32'd0);
        chk("abort held byte_cnt", 32'(byte_cnt), 32'd0);

        ioctl_wr       = 1'b0;
        ioctl_download = 1'b0;
        RESET_N        = 1'b1;
        repeat (2) @(posedge clk_sys);
        #1;
        chk("post_abort core_reset", 32'(core_reset), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
